mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the processor data-store bus (MemWrite/DataAdr/WriteData).
//  Sits beside data RAM and watches the same store bus. A store to TX_ADDR queues WriteData[7:0] in a FIFO.
//  An 8N1 serializer drains the FIFO onto tx.
//  A status word is readable at STATUS_ADDR; the top level muxes it into ReadData when status_sel=1.
// PARAMETERS
//  CLK_DIV      434           clocks per UART bit (50 MHz / 115200); legal range 2..65535
//  TX_ADDR      32'h0000_0C00 store address that pushes a byte
//  STATUS_ADDR  32'h0000_0C04 status read address; a store here clears overflow
//  FIFO_DEPTH   16            FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   synchronous, active-high reset
//  MemWrite     in   1   store strobe from processor
//  DataAdr      in   32  store/load address (ALU result)
//  WriteData    in   32  store data; only [7:0] used
//  status_sel   out  1   comb: 1 when DataAdr==STATUS_ADDR
//  status_data  out  32  comb: {28'b0, overflow, busy, full, empty}
//  tx           out  1   registered serial line, idle high
//  busy         out  1   1 while a frame is in START/DATA/STOP
// BEHAVIOUR
//  Reset (sync, wins over all else): tx=1, busy=0, FIFO empty (empty=1, full=0), overflow=0, FSM=IDLE, counters=0.
//  Reset mid-frame aborts the frame: tx=1 after the reset edge, and queued bytes are discarded.
//  Push: at an edge with MemWrite=1 && DataAdr==TX_ADDR (exact 32-bit compare):
//   - If the pre-edge count < FIFO_DEPTH, WriteData[7:0] is written.
//   - Otherwise the byte is dropped and overflow is set (sticky).
//  Clear: MemWrite=1 && DataAdr==STATUS_ADDR clears overflow at that edge; WriteData is ignored.
//  Stores to any other address are ignored. MemWrite=0 never changes state.
//  FIFO: count is 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
//   - Simultaneous push+pop (count 1..DEPTH-1): count unchanged, both happen.
//   - A push when count==DEPTH is dropped even if a pop occurs at the same edge.
//   - empty=(count==0); full=(count==FIFO_DEPTH).
//  FSM states: IDLE, START, DATA, STOP. Baud counter bcnt counts CLK_DIV-1 down to 0 in each bit.
//   - IDLE: tx=1, busy=0. If !empty: pop the head into shreg, bcnt=CLK_DIV-1, go to START.
//     A byte pushed at edge E0 is popped at E1, and tx=0 from E1.
//   - START: tx=0 for CLK_DIV clocks. At bcnt==0: go to DATA, bit=0, reload bcnt.
//   - DATA: tx=shreg[0] (LSB first) for CLK_DIV clocks per bit.
//     At bcnt==0: shift right, bit++. After bit 7, go to STOP.
//   - STOP: tx=1 for CLK_DIV clocks, then go to IDLE.
//  Frame = 10*CLK_DIV clocks. Back-to-back bytes have exactly 1 idle clock (the IDLE cycle) between stop and start.
//  busy is registered: 1 from the edge entering START through the last STOP clock.
//  status_sel and status_data are combinational and reflect the pre-edge register state.
// TESTING (CLK_DIV=4, FIFO_DEPTH=16 unless noted)
//  1. Store 0x55 to 0xC00 at E0 -> tx=0 after E1 for 4 clks, then 1,0,1,0,1,0,1,0 (4 clks each),
//     then 1 for 4 clks. busy=1 for 40 clks, then empty=1, busy=0.
//  2. Store 0xA5 and 0x3C on consecutive cycles -> two frames 0xA5 then 0x3C,
//     exactly 1 clk of tx=1 between the stop of frame 1 and the start of frame 2.
//  3. With CLK_DIV=1000: push 18 bytes back-to-back; the first is popped at E1, 16 fit, 1 is dropped
//     -> full=1, overflow=1, status_data=32'h0000_000E.
//     Then store to 0xC04 -> overflow=0; the 16 bytes transmit in order.
//  4. Store to 0xC08 and 0xC01, and MemWrite=0 with DataAdr=0xC00 -> no push, tx stays 1, empty=1.
//     DataAdr=0xC04 -> status_sel=1.
//  5. Assert reset for 1 clk during the DATA bit 3 of a frame with 3 bytes queued
//     -> tx=1, busy=0, empty=1, overflow=0 after the edge; no further frames.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-bus mapped 8N1 UART transmitter with a byte FIFO and a status word.
module mmio_uart_tx #(
    parameter int          CLK_DIV     = 434,
    parameter logic [31:0] TX_ADDR     = 32'h0000_0C00,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0C04,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        status_sel,
    output logic [31:0] status_data,
    output logic        tx,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BRELOAD = 16'(CLK_DIV - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic overflow, empty, full, push_req, push, pop, clr, tx_n, busy_n;
    logic [15:0] bcnt, bcnt_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, shreg_n;
    logic unused_ok;
    assign unused_ok = ^WriteData[31:8];
    assign push_req = MemWrite && DataAdr == TX_ADDR;
    assign clr = MemWrite && DataAdr == STATUS_ADDR;
    assign empty = count == '0;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    // A push into a full FIFO is dropped even when a pop frees a slot at the same edge.
    assign push = push_req && !full;
    assign pop = state == IDLE && !empty;
    assign status_sel = DataAdr == STATUS_ADDR;
    assign status_data = {28'b0, overflow, busy, full, empty};
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= WriteData[7:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= (push_req && full) || (overflow && !clr);
        end
    end
    always_comb begin
        state_n = state;
        bcnt_n = bcnt == '0 ? bcnt : bcnt - 16'd1;
        bit_n = bit_idx;
        shreg_n = shreg;
        case (state)
            IDLE: if (pop) begin
                state_n = START;
                bcnt_n = BRELOAD;
                shreg_n = mem[rd_ptr];
            end
            START: if (bcnt == '0) begin
                state_n = DATA;
                bcnt_n = BRELOAD;
                bit_n = 3'd0;
            end
            DATA: if (bcnt == '0) begin
                bcnt_n = BRELOAD;
                shreg_n = shreg >> 1;
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = STOP;
            end
            STOP: if (bcnt == '0) begin
                state_n = IDLE;
                bcnt_n = '0;
            end
            default: state_n = IDLE;
        endcase
        // tx is registered, so it is derived from the state being entered.
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bcnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            tx <= 1'b1;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            bcnt <= bcnt_n;
            bit_idx <= bit_n;
            shreg <= shreg_n;
            tx <= tx_n;
            busy <= busy_n;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: vector table, hand sequences and random stores against a frame-level model.
module tb_mmio_uart_tx;
    localparam int DIV = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] TXA = 32'h0000_0C00;
    localparam logic [31:0] STA = 32'h0000_0C04;
    logic clk = 1'b0, reset, MemWrite, status_sel, tx, busy;
    logic [31:0] DataAdr, WriteData, status_data;
    mmio_uart_tx #(.CLK_DIV(DIV), .TX_ADDR(TXA), .STATUS_ADDR(STA), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .status_sel(status_sel), .status_data(status_data), .tx(tx), .busy(busy)
    );
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    // Model: queued bytes, the byte on the wire and clocks elapsed since its frame began.
    logic [7:0] q[$];
    logic [7:0] cur;
    bit active, ovf;
    int t;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction
    function automatic logic m_tx();
        int b;
        b = t / DIV;
        if (!active || b > 8) return 1'b1;
        return b == 0 ? 1'b0 : cur[b-1];
    endfunction
    function automatic logic [31:0] m_status();
        return {28'b0, ovf, active, q.size() == DEPTH, q.size() == 0};
    endfunction
    function automatic void model_edge(logic r, logic m, logic [31:0] a, logic [31:0] w);
        int pre;
        if (r) begin
            q.delete();
            active = 0;
            ovf = 0;
            return;
        end
        pre = q.size();
        if (active) begin
            t++;
            if (t == 10 * DIV) active = 0;
        end else if (pre > 0) begin
            cur = q.pop_front();
            active = 1;
            t = 0;
        end
        if (m && a == TXA) begin
            if (pre < DEPTH) q.push_back(w[7:0]);
            else ovf = 1;
        end
        if (m && a == STA) ovf = 0;
    endfunction
    task automatic step(input logic r, input logic m, input logic [31:0] a, input logic [31:0] w);
        reset = r;
        MemWrite = m;
        DataAdr = a;
        WriteData = w;
        @(posedge clk);
        model_edge(r, m, a, w);
        #1;
        chk("tx", 32'(tx), 32'(m_tx()));
        chk("busy", 32'(busy), 32'(active));
        chk("status_data", status_data, m_status());
        chk("status_sel", 32'(status_sel), 32'(a == STA));
    endtask
    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask
    task automatic drain();
        int k = 0;
        while ((active || q.size() != 0) && k < 2000) begin
            idle(1);
            k++;
        end
        chk("drain_timeout", 32'(k < 2000), 32'd1);
        idle(2);
    endtask
    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        exp_sel;
        logic [31:0] exp_status;
    } vec_t;
    vec_t tbl[7];
    logic [9:0] pat;
    initial begin
        tbl[0] = '{1'b1, 32'h0000_0C08, 32'h0000_0055, 1'b0, 32'h1};
        tbl[1] = '{1'b1, 32'h0000_0C01, 32'h0000_00AA, 1'b0, 32'h1};
        tbl[2] = '{1'b0, 32'h0000_0C00, 32'h0000_0077, 1'b0, 32'h1};
        tbl[3] = '{1'b0, 32'h0000_0C04, 32'h0000_0000, 1'b1, 32'h1};
        tbl[4] = '{1'b1, 32'h0000_0C04, 32'hFFFF_FFFF, 1'b1, 32'h1};
        tbl[5] = '{1'b1, 32'h0001_0C00, 32'h0000_0012, 1'b0, 32'h1};
        tbl[6] = '{1'b1, 32'h0000_0000, 32'h0000_0034, 1'b0, 32'h1};
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_status", status_data, 32'h1);
        // Decode table: none of these may push.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, tbl[i].mw, tbl[i].adr, tbl[i].wd);
            chk("tbl_sel", 32'(status_sel), 32'(tbl[i].exp_sel));
            chk("tbl_status", status_data, tbl[i].exp_status);
            chk("tbl_tx", 32'(tx), 32'd1);
        end
        idle(3);
        chk("tbl_idle", 32'({tx, busy}), 32'b10);
        // Single frame of 0x55 against a hand-built waveform.
        pat = {1'b1, 8'h55, 1'b0};
        step(1'b0, 1'b1, TXA, 32'hDEAD_BE55);
        for (int k = 0; k < 10 * DIV; k++) begin
            idle(1);
            chk("t1_tx", 32'(tx), 32'(pat[k/DIV]));
            chk("t1_busy", 32'(busy), 32'd1);
        end
        idle(1);
        chk("t1_end", status_data, 32'h1);
        // Back-to-back frames with one idle clock between them.
        step(1'b0, 1'b1, TXA, 32'h0000_00A5);
        step(1'b0, 1'b1, TXA, 32'h0000_003C);
        idle(10 * DIV - 1);
        chk("t2_last_stop", 32'({tx, busy}), 32'b11);
        idle(1);
        chk("t2_gap", 32'({tx, busy}), 32'b10);
        idle(1);
        chk("t2_start2", 32'({tx, busy}), 32'b01);
        drain();
        // Overflow: 18 stores, 16 stay queued, one is dropped.
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, TXA, $urandom);
        chk("t3_status_full", status_data, 32'h0000_000E);
        step(1'b0, 1'b1, STA, 32'hFFFF_FFFF);
        chk("t3_status_clr", status_data, 32'h0000_0006);
        drain();
        // Random stores, occasional resets.
        for (int i = 0; i < 1500; i++) begin
            int s;
            logic [31:0] a;
            s = int'($urandom_range(0, 9));
            a = s < 3 ? TXA : s < 4 ? STA : s < 6 ? TXA ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();
        // Reset during data bit 3 with three bytes still queued.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, TXA, 32'($urandom_range(0, 255)));
        idle(15);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        chk("t5_reset", {status_data[3:0], tx, busy}, 32'b0001_10);
        idle(60);
        chk("t5_quiet", {status_data[3:0], tx, busy}, 32'b0001_10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
